// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, access size codes and ls_info bit map
// for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [2:0] SZ_D = 3'd3;

  localparam int LS_LB  = 10;
  localparam int LS_LBU = 9;
  localparam int LS_LD  = 8;
  localparam int LS_LH  = 7;
  localparam int LS_LHU = 6;
  localparam int LS_LW  = 5;
  localparam int LS_LWU = 4;
  localparam int LS_SB  = 3;
  localparam int LS_SD  = 2;
  localparam int LS_SH  = 1;
  localparam int LS_SW  = 0;

  function automatic logic [2:0] ls_size(input logic [10:0] info);
    logic [2:0] s;
    unique case (1'b1)
      info[LS_LB], info[LS_LBU], info[LS_SB]: s = SZ_B;
      info[LS_LH], info[LS_LHU], info[LS_SH]: s = SZ_H;
      info[LS_LW], info[LS_LWU], info[LS_SW]: s = SZ_W;
      info[LS_LD], info[LS_SD]:               s = SZ_D;
      default:                                s = SZ_B;
    endcase
    return s;
  endfunction

  function automatic logic ls_signed(input logic [10:0] info);
    return info[LS_LB] | info[LS_LH] | info[LS_LW];
  endfunction

endpackage

// File: rtl/lsu_align_lane.sv
// lsu_lane_align: byte strobes, store lane shift, load lane shift and
// sign/zero extension for one naturally aligned access.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]                  size,
  input  logic [$clog2(XLEN/8)-1:0]   off,
  input  logic                        sign,
  input  logic [XLEN-1:0]             wdata,
  input  logic [XLEN-1:0]             rdata,
  output logic [XLEN/8-1:0]           wstrb,
  output logic [XLEN-1:0]             bus_wdata,
  output logic [XLEN-1:0]             load_data
);

  localparam int NB = XLEN / 8;

  logic [NB-1:0]   smask;
  logic [XLEN-1:0] keep;
  logic [XLEN-1:0] shifted;
  logic            msb;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    unique case (size)
      SZ_B: begin
        smask = NB'(8'h01);
        keep  = XLEN'(64'hFF);
        msb   = shifted[7];
      end
      SZ_H: begin
        smask = NB'(8'h03);
        keep  = XLEN'(64'hFFFF);
        msb   = shifted[15];
      end
      SZ_W: begin
        smask = NB'(8'h0F);
        keep  = XLEN'(64'hFFFF_FFFF);
        msb   = shifted[31];
      end
      default: begin
        smask = '1;
        keep  = '1;
        msb   = shifted[XLEN-1];
      end
    endcase
    // upper bits come from the sign only for signed loads
    load_data = (shifted & keep) | ((sign & msb) ? ~keep : '0);
    wstrb     = smask << off;
    bus_wdata = wdata << {off, 3'b000};
  end

endmodule

// File: rtl/lsu_align.sv
// lsu_align: MEM-stage load/store unit with valid/ready bus handshake.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int AW   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_read_i,
  input  logic                mem_write_i,
  input  logic [AW-1:0]       mem_addr_i,
  input  logic [XLEN-1:0]     mem_wdata_i,
  input  logic [10:0]         ls_info_i,
  input  logic                rd_wen_i,
  input  logic [4:0]          rd_addr_i,
  input  logic [XLEN-1:0]     rd_data_i,
  output logic                lsu_bus_valid_o,
  input  logic                lsu_bus_ready_i,
  output logic                lsu_bus_wen_o,
  output logic [AW-1:0]       lsu_bus_addr_o,
  output logic [2:0]          lsu_bus_size_o,
  output logic [XLEN-1:0]     lsu_bus_wdata_o,
  output logic [XLEN/8-1:0]   lsu_bus_wstrb_o,
  input  logic                lsu_bus_rvalid_i,
  input  logic [XLEN-1:0]     lsu_bus_rdata_i,
  output logic                lsu_rd_wen_o,
  output logic [4:0]          lsu_rd_addr_o,
  output logic [XLEN-1:0]     lsu_rd_data_o,
  output logic                lsu_hold_o,
  output logic                lsu_misalign_o,
  output logic [AW-1:0]       lsu_badaddr_o
);

  localparam int OW = $clog2(XLEN / 8);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] load_q;
  logic [XLEN-1:0] ld_data;
  logic            req;
  logic [2:0]      size;
  logic [OW-1:0]   off_raw;
  logic [OW-1:0]   amask;
  logic [OW-1:0]   off;
  logic            trap;

  assign req     = mem_read_i | mem_write_i;
  assign size    = ls_size(ls_info_i);
  assign off_raw = mem_addr_i[OW-1:0];

  always_comb begin
    unique case (size)
      SZ_B:    amask = '0;
      SZ_H:    amask = OW'(1);
      SZ_W:    amask = OW'(3);
      default: amask = '1;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign off  = off_raw;
  assign trap = |(off_raw & amask);
`else
  // without trapping, accesses are silently aligned down
  assign off  = off_raw & ~amask;
  assign trap = 1'b0;
`endif

  assign lsu_bus_wen_o  = mem_write_i;
  assign lsu_bus_addr_o = {mem_addr_i[AW-1:OW], off};
  assign lsu_bus_size_o = size;

  lsu_lane_align #(.XLEN(XLEN)) u_lane (
    .size      (size),
    .off       (off),
    .sign      (ls_signed(ls_info_i)),
    .wdata     (mem_wdata_i),
    .rdata     (lsu_bus_rdata_i),
    .wstrb     (lsu_bus_wstrb_o),
    .bus_wdata (lsu_bus_wdata_o),
    .load_data (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_WAIT && lsu_bus_rvalid_i) begin
        load_q <= ld_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req) state_d = trap ? S_DONE : S_REQ;
      S_REQ:  if (lsu_bus_ready_i) state_d = S_WAIT;
      S_WAIT: if (lsu_bus_rvalid_i) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // reset gating keeps every handshake output low while rst_n is low
  always_comb begin
    lsu_bus_valid_o = 1'b0;
    lsu_hold_o      = 1'b0;
    lsu_rd_wen_o    = 1'b0;
    lsu_rd_addr_o   = '0;
    lsu_rd_data_o   = '0;
    lsu_misalign_o  = 1'b0;
    lsu_badaddr_o   = '0;
    if (rst_n) begin
      lsu_bus_valid_o = (state_q == S_REQ);
      lsu_hold_o      = req & (state_q != S_DONE);
      lsu_rd_addr_o   = rd_addr_i;
      lsu_rd_data_o   = rd_data_i;
      unique case (state_q)
        S_IDLE: lsu_rd_wen_o = rd_wen_i & ~req;
        S_DONE: begin
          if (trap) begin
            lsu_misalign_o = 1'b1;
            lsu_badaddr_o  = mem_addr_i;
          end else if (mem_read_i) begin
            lsu_rd_wen_o  = 1'b1;
            lsu_rd_data_o = load_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: directed vector bench for lsu_align (XLEN=64 and 32).
// Misalignment expectations follow LSU_MISALIGN_TRAP_EN.
module tb_lsu_align;

  localparam logic [10:0] LB  = 11'h400;
  localparam logic [10:0] LBU = 11'h200;
  localparam logic [10:0] LD  = 11'h100;
  localparam logic [10:0] LH  = 11'h080;
  localparam logic [10:0] LHU = 11'h040;
  localparam logic [10:0] LW  = 11'h020;
  localparam logic [10:0] LWU = 11'h010;
  localparam logic [10:0] SB  = 11'h008;
  localparam logic [10:0] SD  = 11'h004;
  localparam logic [10:0] SH  = 11'h002;
  localparam logic [10:0] SW  = 11'h001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [63:0] mem_addr = '0, mem_wdata = '0;
  logic [10:0] ls_info = '0;
  logic        rd_wen_i = 1'b0;
  logic [4:0]  rd_addr_i = '0;
  logic [63:0] rd_data_i = '0;
  logic        bus_ready = 1'b0, bus_rvalid = 1'b0;
  logic [63:0] bus_rdata = '0;
  logic        bus_valid, bus_wen, o_rd_wen, hold, misalign;
  logic [63:0] bus_addr, bus_wdata, o_rd_data, badaddr;
  logic [2:0]  bus_size;
  logic [7:0]  bus_wstrb;
  logic [4:0]  o_rd_addr;

  logic        n_read = 1'b0, n_write = 1'b0;
  logic [31:0] n_addr = '0, n_wdata = '0;
  logic [10:0] n_info = '0;
  logic        n_rd_wen_i = 1'b0;
  logic [4:0]  n_rd_addr_i = '0;
  logic [31:0] n_rd_data_i = '0;
  logic        n_ready = 1'b0, n_rvalid = 1'b0;
  logic [31:0] n_rdata = '0;
  logic        n_valid, n_wen, n_rd_wen, n_hold, n_mis;
  logic [31:0] n_baddr, n_bwdata, n_rd_data, n_bad;
  logic [2:0]  n_size;
  logic [3:0]  n_strb;
  logic [4:0]  n_rd_addr;

  always #5 clk = ~clk;

  lsu_align #(.XLEN(64), .AW(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_i(mem_read), .mem_write_i(mem_write),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .ls_info_i(ls_info),
    .rd_wen_i(rd_wen_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
    .lsu_bus_valid_o(bus_valid), .lsu_bus_ready_i(bus_ready),
    .lsu_bus_wen_o(bus_wen), .lsu_bus_addr_o(bus_addr),
    .lsu_bus_size_o(bus_size), .lsu_bus_wdata_o(bus_wdata),
    .lsu_bus_wstrb_o(bus_wstrb),
    .lsu_bus_rvalid_i(bus_rvalid), .lsu_bus_rdata_i(bus_rdata),
    .lsu_rd_wen_o(o_rd_wen), .lsu_rd_addr_o(o_rd_addr),
    .lsu_rd_data_o(o_rd_data), .lsu_hold_o(hold),
    .lsu_misalign_o(misalign), .lsu_badaddr_o(badaddr)
  );

  lsu_align #(.XLEN(32), .AW(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .mem_read_i(n_read), .mem_write_i(n_write),
    .mem_addr_i(n_addr), .mem_wdata_i(n_wdata),
    .ls_info_i(n_info),
    .rd_wen_i(n_rd_wen_i), .rd_addr_i(n_rd_addr_i), .rd_data_i(n_rd_data_i),
    .lsu_bus_valid_o(n_valid), .lsu_bus_ready_i(n_ready),
    .lsu_bus_wen_o(n_wen), .lsu_bus_addr_o(n_baddr),
    .lsu_bus_size_o(n_size), .lsu_bus_wdata_o(n_bwdata),
    .lsu_bus_wstrb_o(n_strb),
    .lsu_bus_rvalid_i(n_rvalid), .lsu_bus_rdata_i(n_rdata),
    .lsu_rd_wen_o(n_rd_wen), .lsu_rd_addr_o(n_rd_addr),
    .lsu_rd_data_o(n_rd_data), .lsu_hold_o(n_hold),
    .lsu_misalign_o(n_mis), .lsu_badaddr_o(n_bad)
  );

  typedef struct {
    logic [10:0] info;
    logic        rd;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [63:0] exp_data;
    logic [2:0]  size;
    logic [7:0]  strb;
    logic [63:0] bwdata;
  } vec_t;

  vec_t vt[12];
  int total = 0;
  int bad = 0;

  int          r_cyc, r_vcnt;
  logic        r_done, r_wen, r_mis, r_bwen;
  logic [63:0] r_data, r_bad, r_addr, r_bwdata;
  logic [2:0]  r_size;
  logic [7:0]  r_strb;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic setup(input logic rd, input logic [10:0] info,
                       input logic [63:0] addr, input logic [63:0] wd);
    @(negedge clk);
    mem_read  = rd;
    mem_write = ~rd;
    ls_info   = info;
    mem_addr  = addr;
    mem_wdata = wd;
  endtask

  // bridge model: accept after rdy_dly valid cycles, respond rv_dly later
  task automatic access(input int rdy_dly, input int rv_dly,
                        input logic early, input logic [63:0] rdata);
    int   rc;
    int   wc;
    logic acc;
    rc = 0; wc = 0; acc = 1'b0;
    r_cyc = 0; r_vcnt = 0; r_done = 1'b0;
    r_wen = 1'b0; r_mis = 1'b0; r_data = '0; r_bad = '0;
    #1;
    for (int k = 0; k < 40 && !r_done; k++) begin
      r_cyc++;
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      if (!hold) begin
        r_done = 1'b1;
        r_wen  = o_rd_wen;
        r_data = o_rd_data;
        r_mis  = misalign;
        r_bad  = badaddr;
      end else if (bus_valid) begin
        r_vcnt++;
        r_addr = bus_addr; r_size = bus_size; r_bwen = bus_wen;
        r_bwdata = bus_wdata; r_strb = bus_wstrb;
        if (rc == rdy_dly) begin
          bus_ready = 1'b1;
          acc = 1'b1;
          if (early) begin
            bus_rvalid = 1'b1;
            bus_rdata  = ~rdata;
          end
        end
        rc++;
      end else if (acc) begin
        if (wc == rv_dly) begin
          bus_rvalid = 1'b1;
          bus_rdata  = rdata;
        end
        wc++;
      end
      if (!r_done) begin
        @(negedge clk);
        #1;
      end
    end
    check("access_done", 64'(r_done), 64'd1);
    mem_read = 1'b0; mem_write = 1'b0; ls_info = '0;
  endtask

  initial begin
    vt[0]  = '{LB,  1'b1, 64'h1003, 64'h0, 64'h0000_0000_8000_0000,
               64'hFFFF_FFFF_FFFF_FF80, 3'd0, 8'h08, 64'h0};
    vt[1]  = '{SH,  1'b0, 64'h1006, 64'hBEEF, 64'h0,
               64'h0, 3'd1, 8'hC0, 64'hBEEF_0000_0000_0000};
    vt[2]  = '{LBU, 1'b1, 64'h1007, 64'h0, 64'hA500_0000_0000_0000,
               64'hA5, 3'd0, 8'h80, 64'h0};
    vt[3]  = '{LH,  1'b1, 64'h1002, 64'h0, 64'h0000_0000_8001_0000,
               64'hFFFF_FFFF_FFFF_8001, 3'd1, 8'h0C, 64'h0};
    vt[4]  = '{LHU, 1'b1, 64'h1004, 64'h0, 64'h0000_9ABC_0000_0000,
               64'h9ABC, 3'd1, 8'h30, 64'h0};
    vt[5]  = '{LW,  1'b1, 64'h1004, 64'h0, 64'hDEAD_BEEF_0000_0000,
               64'hFFFF_FFFF_DEAD_BEEF, 3'd2, 8'hF0, 64'h0};
    vt[6]  = '{LWU, 1'b1, 64'h1000, 64'h0, 64'h1234_5678_CAFE_F00D,
               64'hCAFE_F00D, 3'd2, 8'h0F, 64'h0};
    vt[7]  = '{LD,  1'b1, 64'h1008, 64'h0, 64'h0123_4567_89AB_CDEF,
               64'h0123_4567_89AB_CDEF, 3'd3, 8'hFF, 64'h0};
    vt[8]  = '{SB,  1'b0, 64'h1005, 64'h77, 64'h0,
               64'h0, 3'd0, 8'h20, 64'h0000_7700_0000_0000};
    vt[9]  = '{SW,  1'b0, 64'h1004, 64'h89AB_CDEF, 64'h0,
               64'h0, 3'd2, 8'hF0, 64'h89AB_CDEF_0000_0000};
    vt[10] = '{SD,  1'b0, 64'h1000, 64'h1122_3344_5566_7788, 64'h0,
               64'h0, 3'd3, 8'hFF, 64'h1122_3344_5566_7788};
    vt[11] = '{LW,  1'b1, 64'h1000, 64'h0, 64'h0000_0000_7FFF_FFFF,
               64'h7FFF_FFFF, 3'd2, 8'h0F, 64'h0};

    // reset with a pending request: everything must stay low
    mem_read = 1'b1; ls_info = LW; mem_addr = 64'h1002; rd_wen_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", 64'(bus_valid), 64'd0);
    check("rst_hold", 64'(hold), 64'd0);
    check("rst_rd_wen", 64'(o_rd_wen), 64'd0);
    check("rst_misalign", 64'(misalign), 64'd0);
    check("rst_badaddr", badaddr, 64'd0);
    mem_read = 1'b0; ls_info = '0; rd_wen_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // passthrough with no memory op
    @(negedge clk);
    rd_wen_i = 1'b1; rd_addr_i = 5'd7; rd_data_i = 64'hABC;
    #1;
    check("pass_wen", 64'(o_rd_wen), 64'd1);
    check("pass_addr", 64'(o_rd_addr), 64'd7);
    check("pass_data", o_rd_data, 64'hABC);
    check("pass_hold", 64'(hold), 64'd0);
    rd_wen_i = 1'b0;

    for (int i = 0; i < 12; i++) begin
      setup(vt[i].rd, vt[i].info, vt[i].addr, vt[i].wdata);
      access(0, 0, 1'b0, vt[i].rdata);
      check($sformatf("v%0d_cycles", i), 64'(r_cyc), 64'd4);
      check($sformatf("v%0d_valids", i), 64'(r_vcnt), 64'd1);
      check($sformatf("v%0d_rd_wen", i), 64'(r_wen), 64'(vt[i].rd));
      if (vt[i].rd) check($sformatf("v%0d_rd_data", i), r_data, vt[i].exp_data);
      check($sformatf("v%0d_addr", i), r_addr, vt[i].addr);
      check($sformatf("v%0d_size", i), 64'(r_size), 64'(vt[i].size));
      check($sformatf("v%0d_bus_wen", i), 64'(r_bwen), 64'(!vt[i].rd));
      check($sformatf("v%0d_wstrb", i), 64'(r_strb), 64'(vt[i].strb));
      check($sformatf("v%0d_wdata", i), r_bwdata, vt[i].bwdata);
    end

    // misaligned lw
    setup(1'b1, LW, 64'h1002, 64'h0);
    access(0, 0, 1'b0, 64'h0000_0000_8765_4321);
`ifdef LSU_MISALIGN_TRAP_EN
    check("trap_cycles", 64'(r_cyc), 64'd2);
    check("trap_valids", 64'(r_vcnt), 64'd0);
    check("trap_misalign", 64'(r_mis), 64'd1);
    check("trap_badaddr", r_bad, 64'h1002);
    check("trap_rd_wen", 64'(r_wen), 64'd0);
`else
    check("mis_cycles", 64'(r_cyc), 64'd4);
    check("mis_valids", 64'(r_vcnt), 64'd1);
    check("mis_addr", r_addr, 64'h1000);
    check("mis_data", r_data, 64'hFFFF_FFFF_8765_4321);
    check("mis_misalign", 64'(r_mis), 64'd0);
`endif

    // ready held off 3 cycles, response in the 5th WAIT cycle
    setup(1'b1, LD, 64'h1010, 64'h0);
    access(3, 4, 1'b0, 64'h5555_AAAA_0F0F_F0F0);
    check("stall_valids", 64'(r_vcnt), 64'd4);
    check("stall_cycles", 64'(r_cyc), 64'd11);
    check("stall_rd_wen", 64'(r_wen), 64'd1);
    check("stall_data", r_data, 64'h5555_AAAA_0F0F_F0F0);
    @(negedge clk);
    #1;
    check("stall_once_wen", 64'(o_rd_wen), 64'd0);
    check("stall_once_hold", 64'(hold), 64'd0);

    // rvalid alongside ready in REQ must be ignored
    setup(1'b1, LW, 64'h1000, 64'h0);
    access(0, 1, 1'b1, 64'h0000_0000_1234_5678);
    check("early_cycles", 64'(r_cyc), 64'd5);
    check("early_data", r_data, 64'h1234_5678);

    // reset while waiting for the response
    setup(1'b1, LWU, 64'h1000, 64'h0);
    @(negedge clk);
    #1;
    check("mid_valid", 64'(bus_valid), 64'd1);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    #1;
    check("mid_wait_hold", 64'(hold), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus_valid), 64'd0);
    check("mid_rst_hold", 64'(hold), 64'd0);
    check("mid_rst_wen", 64'(o_rd_wen), 64'd0);
    mem_read = 1'b0; ls_info = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b1; bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    check("late_rv_wen", 64'(o_rd_wen), 64'd0);
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    check("late_rv_wen2", 64'(o_rd_wen), 64'd0);
    check("late_rv_hold", 64'(hold), 64'd0);
    check("late_rv_valid", 64'(bus_valid), 64'd0);

    // XLEN=32 lhu at 0x22
    @(negedge clk);
    n_read = 1'b1; n_info = LHU; n_addr = 32'h22;
    #1;
    check("x32_idle_hold", 64'(n_hold), 64'd1);
    check("x32_strb", 64'(n_strb), 64'hC);
    @(negedge clk);
    #1;
    check("x32_valid", 64'(n_valid), 64'd1);
    n_ready = 1'b1;
    @(negedge clk);
    n_ready = 1'b0;
    n_rvalid = 1'b1; n_rdata = 32'hF00D_0000;
    @(negedge clk);
    n_rvalid = 1'b0;
    #1;
    check("x32_hold", 64'(n_hold), 64'd0);
    check("x32_rd_wen", 64'(n_rd_wen), 64'd1);
    check("x32_rd_data", 64'(n_rd_data), 64'h0000_F00D);
    n_read = 1'b0; n_info = '0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_align.md
# lsu_align

Parametrised load/store unit for the MEM stage: issues one memory access per instruction over a valid/ready request and response handshake, generates byte strobes, lane-shifts sub-word data for any naturally aligned offset, and sign/zero-extends loads. Sits between EX/MEM pipeline register and the data-side bus bridge; stalls the pipeline via `lsu_hold_o` until the response arrives.

## Interface
- `XLEN`, 64, data width; legal values 32 or 64.
- `AW`, 64, address width.
- `clk` in 1 — clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `mem_read_i` / `mem_write_i` in 1 — load / store request (mutually exclusive).
- `mem_addr_i` in AW — byte address.
- `mem_wdata_i` in XLEN — store data, LSB-justified.
- `ls_info_i` in 11 — one-hot op: [10]lb [9]lbu [8]ld [7]lh [6]lhu [5]lw [4]lwu [3]sb [2]sd [1]sh [0]sw; ld/sd/lwu must be 0 when XLEN=32.
- `rd_wen_i` in 1, `rd_addr_i` in 5, `rd_data_i` in XLEN — non-memory writeback passthrough.
- `lsu_bus_valid_o` out 1, `lsu_bus_ready_i` in 1 — request handshake.
- `lsu_bus_wen_o` out 1; `lsu_bus_addr_o` out AW; `lsu_bus_size_o` out 3 (0=b,1=h,2=w,3=d).
- `lsu_bus_wdata_o` out XLEN (lane-shifted); `lsu_bus_wstrb_o` out XLEN/8.
- `lsu_bus_rvalid_i` in 1, `lsu_bus_rdata_i` in XLEN — response (loads and store acks).
- `lsu_rd_wen_o` out 1, `lsu_rd_addr_o` out 5, `lsu_rd_data_o` out XLEN — writeback.
- `lsu_hold_o` out 1 — pipeline stall.
- `lsu_misalign_o` out 1, `lsu_badaddr_o` out AW — misalignment exception.

## Operation
- FSM: IDLE, REQ, WAIT, DONE. IDLE & (read|write) & aligned -> REQ; IDLE & req & misaligned -> DONE (trap). REQ & ready -> WAIT. WAIT & rvalid -> DONE. DONE -> IDLE unconditionally.
- `lsu_bus_valid_o` = (state==REQ); bus address/size/wen/wdata/wstrb driven combinationally from inputs, held stable by pipeline via hold.
- off = addr[log2(XLEN/8)-1:0]. wstrb = size-mask << off; wdata = store data << 8*off.
- Load: rdata >> 8*off, then extend per op; result registered on WAIT&rvalid into load register.
- Misaligned: h with off[0]≠0, w with off[1:0]≠0, d with off[2:0]≠0. b never misaligned.
- `lsu_hold_o` = req & state≠DONE (includes IDLE cycle with pending req).
- DONE: load -> `lsu_rd_wen_o`=1, data=load register; store -> `lsu_rd_wen_o`=0; trap -> `lsu_rd_wen_o`=0, `lsu_misalign_o`=1, `lsu_badaddr_o`=mem_addr_i.
- No memory op in IDLE: rd_* pass through combinationally.
- `lsu_bus_rvalid_i` ignored outside WAIT; `lsu_bus_ready_i` ignored outside REQ.

## Timing
- Reset: state IDLE, load register 0; while rst_n low all outputs 0 (valid, hold, rd_wen, misalign, badaddr).
- Minimum access (ready in first REQ cycle, rvalid next cycle): 4 cycles req-to-writeback (IDLE, REQ, WAIT, DONE); one DONE cycle with hold=0 where pipeline advances.
- Trap: 2 cycles (IDLE, DONE), no bus valid ever raised.
- Reset mid-access: valid drops asynchronously; any later response is dropped in IDLE.
- Ready and rvalid in the same REQ cycle: rvalid ignored; bridge must not respond before accept.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misalignment checking and trap path as above.
- Undefined: no trap; offset bits below access size are forced to 0 in the bus address and lane logic (access aligned down); `lsu_misalign_o`/`lsu_badaddr_o` tied 0.

## Structure
- Package `lsu_pkg`: FSM state encodings, size codes, `ls_info_i` bit indices.
- Sub-module `lsu_lane_align`: combinational strobe/shift/extend for both directions, parametrised by XLEN.

## Test plan
- XLEN=64, lb at 0x1003, rdata=0x0000_0000_8000_0000 -> rd_data=0xFFFF_FFFF_FFFF_FF80, rd_wen=1 in DONE, cycle 4.
- sh at 0x1006, wdata=0xBEEF -> wstrb=0xC0, bus wdata=0xBEEF_0000_0000_0000, rd_wen=0.
- lw at 0x1002 with trap enabled -> no bus valid, misalign=1, badaddr=0x1002, 2 cycles; trap disabled -> bus addr 0x1000.
- ready low for 3 cycles, rvalid 5 cycles later -> valid held 4 cycles, hold high throughout, DONE once.
- Reset asserted in WAIT, rvalid after release -> outputs 0, no writeback.
- XLEN=32, lhu at 0x22, rdata=0xF00D_0000 -> rd_data=0x0000_F00D.
